// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Registered AND/XOR/OR/PASS logic unit with optional inversion,
//            8085-style flags and a 2-entry valid/ready output buffer.
//            Optional feature macro: LOGIC_FLAGS_EN (flag generation/storage).
// Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       selOp,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] outC,
    output logic [4:0]       outFlag,
    output logic             outValid,
    input  logic             outReady
);

    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_XOR  = 2'b01;
    localparam logic [1:0] c_OP_OR   = 2'b10;

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_dataHead;
    logic [WIDTH-1:0] r_dataTail;

    logic             w_accept;
    logic             w_pop;
    logic             w_loadHead;
    logic             w_shift;
    logic             w_loadTail;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_result;

    assign w_accept = inValid & inReady;
    assign w_pop    = outValid & outReady;

    always_comb begin
        w_raw = inA;
        case (selOp[1:0])
            c_OP_AND: w_raw = inA & inB;
            c_OP_XOR: w_raw = inA ^ inB;
            c_OP_OR:  w_raw = inA | inB;
            default:  w_raw = inA;
        endcase
        w_result = selOp[2] ? ~w_raw : w_raw;
    end

    // Buffer is a 2-deep shift register: head is always slot 0, so the
    // data and flag storage share the same three load controls.
    assign w_loadHead = w_accept & ((r_count == 2'd0) | ((r_count == 2'd1) & w_pop));
    assign w_shift    = w_pop & (r_count == 2'd2);
    assign w_loadTail = w_accept & (((r_count == 2'd1) & ~w_pop) | ((r_count == 2'd2) & w_pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_dataHead <= '0;
            r_dataTail <= '0;
        end else begin
            if (w_accept & ~w_pop)
                r_count <= r_count + 2'd1;
            else if (w_pop & ~w_accept)
                r_count <= r_count - 2'd1;

            if (w_loadHead)
                r_dataHead <= w_result;
            else if (w_shift)
                r_dataHead <= r_dataTail;

            if (w_loadTail)
                r_dataTail <= w_result;
        end
    end

    assign outValid = (r_count != 2'd0);
    assign inReady  = ~rst & (r_count != 2'd2);
    assign outC     = outValid ? r_dataHead : '0;

`ifdef LOGIC_FLAGS_EN
    logic [4:0] r_flagHead;
    logic [4:0] r_flagTail;
    logic [4:0] w_flag;

    // {S, Z, AC, P, CY}; CY is never set by logic ops
    always_comb begin
        w_flag = {w_result[WIDTH-1],
                  (w_result == '0),
                  (selOp[1:0] == c_OP_AND),
                  ~^w_result,
                  1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flagHead <= '0;
            r_flagTail <= '0;
        end else begin
            if (w_loadHead)
                r_flagHead <= w_flag;
            else if (w_shift)
                r_flagHead <= r_flagTail;

            if (w_loadTail)
                r_flagTail <= w_flag;
        end
    end

    assign outFlag = outValid ? r_flagHead : 5'b00000;
`else
    assign outFlag = 5'b00000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Scoreboard bench for logic_unit_pipe (8-bit and 16-bit builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  inA, inB, outC;
    logic [2:0]  selOp;
    logic        inValid, inReady, outValid, outReady;
    logic [4:0]  outFlag;

    logic [15:0] inA16, inB16, outC16;
    logic [2:0]  selOp16;
    logic        inValid16, inReady16, outValid16, outReady16;
    logic [4:0]  outFlag16;

    logic_unit_pipe #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .selOp(selOp),
        .inValid(inValid), .inReady(inReady), .outC(outC), .outFlag(outFlag),
        .outValid(outValid), .outReady(outReady)
    );

    logic_unit_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .inA(inA16), .inB(inB16), .selOp(selOp16),
        .inValid(inValid16), .inReady(inReady16), .outC(outC16), .outFlag(outFlag16),
        .outValid(outValid16), .outReady(outReady16)
    );

    int nVec = 0;
    int nMis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] expFlag(input logic [4:0] f);
`ifdef LOGIC_FLAGS_EN
        return f;
`else
        return 5'b00000;
`endif
    endfunction

    typedef struct packed {
        logic [7:0] c;
        logic [4:0] f;
    } res_t;

    res_t sb[$];

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        res_t       m;
        logic [7:0] r;
        int         ones;
        case (op[1:0])
            2'b00:   r = a & b;
            2'b01:   r = a ^ b;
            2'b10:   r = a | b;
            default: r = a;
        endcase
        if (op[2]) r = ~r;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(r[i]);
        m.c = r;
        m.f = expFlag({r[7], (r == 8'h00), (op[1:0] == 2'b00), (ones % 2 == 0), 1'b0});
        return m;
    endfunction

    // Sample mid-cycle; the queue tracks the buffer contents after each edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            check("rstValid", outValid, 1'b0);
            check("rstReady", inReady, 1'b0);
            check("rstC", outC, 8'h00);
        end else begin
            check("outValid", outValid, sb.size() != 0);
            check("inReady", inReady, sb.size() != 2);
            if (sb.size() != 0) begin
                check("outC", outC, sb[0].c);
                check("outFlag", outFlag, sb[0].f);
            end else begin
                check("emptyC", outC, 8'h00);
                check("emptyFlag", outFlag, 5'b00000);
            end
            if (outValid && outReady && sb.size() != 0) void'(sb.pop_front());
            if (inValid && inReady) sb.push_back(model(inA, inB, selOp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        inA = a; inB = b; selOp = op; inValid = 1'b1;
    endtask

    task automatic randOp();
        setOp(8'($urandom), 8'($urandom), 3'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        inA = '0; inB = '0; selOp = '0; inValid = 1'b0; outReady = 1'b1;
        inA16 = '0; inB16 = '0; selOp16 = '0; inValid16 = 1'b0; outReady16 = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // AND F0 & 3C -> 30, valid for one cycle
        setOp(8'hF0, 8'h3C, 3'b000);
        step();
        inValid = 1'b0;
        @(negedge clk);
        check("t1C", outC, 8'h30);
        check("t1Flag", outFlag, expFlag(5'b00110));
        check("t1Valid", outValid, 1'b1);
        step();
        @(negedge clk);
        check("t1Gone", outValid, 1'b0);

        // XOR AA^AA -> 00; inverted OR 0F|70 -> 80
        step();
        setOp(8'hAA, 8'hAA, 3'b001);
        step();
        inValid = 1'b0;
        @(negedge clk);
        check("t2XorC", outC, 8'h00);
        check("t2XorFlag", outFlag, expFlag(5'b01010));
        step();
        setOp(8'h0F, 8'h70, 3'b110);
        step();
        inValid = 1'b0;
        @(negedge clk);
        check("t2OrC", outC, 8'h80);
        check("t2OrFlag", outFlag, expFlag(5'b10000));
        step();

        // Backpressure: third op stalls until one cycle after the first pop
        outReady = 1'b0;
        randOp(); step();
        randOp(); step();
        randOp();
        check("t3Full", inReady, 1'b0);
        step();
        check("t3Stall", inReady, 1'b0);
        outReady = 1'b1;
        step();
        check("t3ReadyAfterPop", inReady, 1'b1);
        step();
        inValid = 1'b0;
        repeat (4) step();

        // Steady accept+pop at count=1
        for (int i = 0; i < 20; i++) begin
            randOp();
            step();
            if (i > 0) check("t4Valid", outValid, 1'b1);
        end
        inValid = 1'b0;
        repeat (3) step();

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) randOp(); else inValid = 1'b0;
            outReady = ($urandom_range(0, 2) != 0);
            step();
        end
        inValid = 1'b0;
        outReady = 1'b1;
        repeat (4) step();

        // Reset with a full buffer: outputs clear immediately, nothing stale
        outReady = 1'b0;
        randOp(); step();
        randOp(); step();
        inValid = 1'b0;
        check("t5PreFull", inReady, 1'b0);
        rst = 1'b1;
        #1;
        check("t5Valid", outValid, 1'b0);
        check("t5C", outC, 8'h00);
        check("t5Flag", outFlag, 5'b00000);
        check("t5Ready", inReady, 1'b0);
        step();
        step();
        rst = 1'b0;
        outReady = 1'b1;
        #1;
        check("t5ReadyRel", inReady, 1'b1);
        repeat (3) begin
            step();
            check("t5NoStale", outValid, 1'b0);
        end

        // 16-bit PASS 8001
        inA16 = 16'h8001; inB16 = 16'h1234; selOp16 = 3'b011; inValid16 = 1'b1;
        check("t6Ready", inReady16, 1'b1);
        step();
        inValid16 = 1'b0;
        @(negedge clk);
        check("t6Valid", outValid16, 1'b1);
        check("t6C", outC16, 16'h8001);
        check("t6Flag", outFlag16, expFlag(5'b10010));
        step();
        @(negedge clk);
        check("t6Gone", outValid16, 1'b0);

        step();
        if (sb.size() != 0) check("drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
